// File: rtl/free_blk_alloc.sv
// Free-block allocator: a circular free list seeded with every block address after reset,
// handing out one block per cycle to pending channels in round-robin order.
module free_blk_alloc #(
  parameter int PORT_NUM       = 16,
  parameter int BLK_ADDR_WIDTH = 11
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [PORT_NUM-1:0]       i_addr_req,
  output logic [PORT_NUM-1:0]       o_blk_addr_vld,
  output logic [BLK_ADDR_WIDTH-1:0] o_blk_addr,
  input  logic                      i_free_vld,
  input  logic [BLK_ADDR_WIDTH-1:0] i_free_addr,
  output logic [BLK_ADDR_WIDTH:0]   o_free_cnt,
  output logic                      o_init_done,
  output logic                      o_free_ovf
);
  localparam int BLK_NUM = 2 ** BLK_ADDR_WIDTH;
  localparam int PW      = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam logic [BLK_ADDR_WIDTH:0]   CNT_FULL = (BLK_ADDR_WIDTH+1)'(BLK_NUM);
  localparam logic [BLK_ADDR_WIDTH:0]   CNT_ONE  = (BLK_ADDR_WIDTH+1)'(1);
  localparam logic [BLK_ADDR_WIDTH-1:0] PTR_ONE  = BLK_ADDR_WIDTH'(1);
  localparam logic [BLK_ADDR_WIDTH-1:0] PTR_LAST = BLK_ADDR_WIDTH'(BLK_NUM - 1);
  localparam logic [PW-1:0]             LAST_RST = PW'(PORT_NUM - 1);
  localparam logic [PW:0]               PORT_LIM = (PW+1)'(PORT_NUM);

  typedef enum logic [0:0] {ST_INIT = 1'b0, ST_RUN = 1'b1} state_t;

  state_t                    state_r, state_nxt_s;
  logic [BLK_ADDR_WIDTH-1:0] mem_r [BLK_NUM];
  logic [BLK_ADDR_WIDTH-1:0] rd_ptr_r, wr_ptr_r, init_cnt_r;
  logic [BLK_ADDR_WIDTH-1:0] mem_wa_s, mem_wd_s;
  logic [BLK_ADDR_WIDTH:0]   cnt_r, cnt_nxt_s;
  logic [PORT_NUM-1:0]       pend_r, pend_nxt_s, grant_s;
  logic [PW-1:0]             last_r, grant_idx_s;
  logic [PW:0]               cand_s;
  logic                      pop_s, push_s, ovf_s, mem_we_s;

  // Round-robin pick; scanning farthest-first lets the nearest pending channel win.
  always_comb begin
    grant_s     = '0;
    grant_idx_s = last_r;
    pop_s       = 1'b0;
    cand_s      = '0;
    if (state_r == ST_RUN && pend_r != '0 && cnt_r != '0) begin
      for (int i = PORT_NUM; i >= 1; i--) begin
        cand_s      = {1'b0, last_r} + (PW+1)'(i);
        cand_s      = (cand_s >= PORT_LIM) ? (cand_s - PORT_LIM) : cand_s;
        grant_idx_s = pend_r[cand_s[PW-1:0]] ? cand_s[PW-1:0] : grant_idx_s;
        pop_s       = pop_s | pend_r[cand_s[PW-1:0]];
      end
      grant_s[grant_idx_s] = pop_s;
    end else begin
      pop_s = 1'b0;
    end
  end

  // FSM next state, list write port, count update and pending bookkeeping.
  always_comb begin
    state_nxt_s = state_r;
    push_s      = 1'b0;
    ovf_s       = 1'b0;
    mem_we_s    = 1'b0;
    mem_wa_s    = wr_ptr_r;
    mem_wd_s    = i_free_addr;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_INIT: begin
        mem_we_s    = 1'b1;
        mem_wa_s    = init_cnt_r;
        mem_wd_s    = init_cnt_r;
        cnt_nxt_s   = cnt_r + CNT_ONE;
        state_nxt_s = (init_cnt_r == PTR_LAST) ? ST_RUN : ST_INIT;
      end
      ST_RUN: begin
        // A full list still accepts a return when a pop frees a slot the same cycle.
        push_s   = i_free_vld && ((cnt_r != CNT_FULL) || pop_s);
        ovf_s    = i_free_vld && !push_s;
        mem_we_s = push_s;
        if (push_s && !pop_s) begin
          cnt_nxt_s = cnt_r + CNT_ONE;
        end else if (pop_s && !push_s) begin
          cnt_nxt_s = cnt_r - CNT_ONE;
        end else begin
          cnt_nxt_s = cnt_r;
        end
      end
      default: state_nxt_s = ST_INIT;
    endcase
    pend_nxt_s = (pend_r & ~grant_s) | (i_addr_req & ~pend_r);
  end

  // Control state, pointers and registered outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_r        <= ST_INIT;
      rd_ptr_r       <= '0;
      wr_ptr_r       <= '0;
      init_cnt_r     <= '0;
      cnt_r          <= '0;
      pend_r         <= '0;
      last_r         <= LAST_RST;
      o_blk_addr_vld <= '0;
      o_blk_addr     <= '0;
      o_init_done    <= 1'b0;
      o_free_ovf     <= 1'b0;
    end else begin
      state_r        <= state_nxt_s;
      cnt_r          <= cnt_nxt_s;
      pend_r         <= pend_nxt_s;
      o_blk_addr_vld <= grant_s;
      o_init_done    <= (state_nxt_s == ST_RUN);
      o_free_ovf     <= ovf_s;
      if (state_r == ST_INIT) begin
        init_cnt_r <= init_cnt_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r   <= rd_ptr_r + PTR_ONE;
        last_r     <= grant_idx_s;
        o_blk_addr <= mem_r[rd_ptr_r];
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
    end
  end

  // Free-list storage; contents need no reset since INIT rewrites every entry.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && mem_we_s) begin
      mem_r[mem_wa_s] <= mem_wd_s;
    end
  end

  assign o_free_cnt = cnt_r;

endmodule

// File: tb/tb_free_blk_alloc.sv
// Table-driven bench for free_blk_alloc (4 ports, 8 blocks); expected grants go through a scoreboard queue.
module tb_free_blk_alloc;
  localparam int PN = 4;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [PN-1:0] req;
  logic [PN-1:0] vld;
  logic [AW-1:0] addr;
  logic          fv;
  logic [AW-1:0] fa;
  logic [AW:0]   cnt;
  logic          done;
  logic          ovf;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] req;
    logic       fv;
    logic [2:0] fa;
    logic [3:0] ev;
    logic [2:0] ea;
    logic [3:0] ec;
    logic       eo;
  } vec_t;

  logic [PN+AW-1:0] sb_q [$];
  vec_t ta [$];
  vec_t tb [$];

  always #5 clk = ~clk;

  free_blk_alloc #(.PORT_NUM(PN), .BLK_ADDR_WIDTH(AW)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_addr_req(req),
    .o_blk_addr_vld(vld), .o_blk_addr(addr),
    .i_free_vld(fv), .i_free_addr(fa),
    .o_free_cnt(cnt), .o_init_done(done), .o_free_ovf(ovf)
  );

  function automatic vec_t mk(input logic [3:0] r, input logic f, input logic [2:0] a,
                              input logic [3:0] ev, input logic [2:0] ea,
                              input logic [3:0] ec, input logic eo);
    vec_t v;
    v.req = r; v.fv = f; v.fa = a; v.ev = ev; v.ea = ea; v.ec = ec; v.eo = eo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [PN+AW-1:0] e;
    if (vld != '0) begin
      if (sb_q.size() == 0) begin
        chk({tag, " unexpected_grant"}, {vld, addr}, 32'd0);
      end else begin
        e = sb_q.pop_front();
        chk({tag, " grant"}, {vld, addr}, e);
      end
    end
  endtask

  task automatic step(input vec_t v, input string tag);
    req = v.req; fv = v.fv; fa = v.fa;
    if (v.ev != 4'b0000) sb_q.push_back({v.ev, v.ea});
    @(posedge clk); #1;
    sb_check(tag);
    chk({tag, " vld"}, vld, v.ev);
    chk({tag, " cnt"}, cnt, v.ec);
    chk({tag, " ovf"}, ovf, v.eo);
  endtask

  task automatic do_reset(input logic free_in_init, input string tag);
    int n;
    logic ovf_seen;
    rst_n = 1'b0; req = '0; fv = 1'b0; fa = '0;
    @(posedge clk); #1;
    chk({tag, " rst_vld"}, vld, 32'd0);
    chk({tag, " rst_addr"}, addr, 32'd0);
    chk({tag, " rst_cnt"}, cnt, 32'd0);
    chk({tag, " rst_done"}, done, 32'd0);
    chk({tag, " rst_ovf"}, ovf, 32'd0);
    rst_n = 1'b1; fv = free_in_init; fa = 3'd3;
    n = 0; ovf_seen = 1'b0;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
      ovf_seen = ovf_seen | (ovf === 1'b1);
    end
    fv = 1'b0;
    chk({tag, " init_cycles"}, n, 32'd8);
    chk({tag, " init_cnt"}, cnt, 32'd8);
    chk({tag, " init_ovf"}, ovf_seen, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req = '0; fv = 1'b0; fa = '0;

    // Table A: burst, returns, overflow, full pop+push, round-robin, merge, mid-burst
    ta.push_back(mk(4'b1111, 1'b0, 3'd0, 4'b0000, 3'd0, 4'd8, 1'b0));
    ta.push_back(mk(4'b0000, 1'b0, 3'd0, 4'b0001, 3'd0, 4'd7, 1'b0));
    ta.push_back(mk(4'b0000, 1'b0, 3'd0, 4'b0010, 3'd1, 4'd6, 1'b0));
    ta.push_back(mk(4'b0000, 1'b0, 3'd0, 4'b0100, 3'd2, 4'd5, 1'b0));
    ta.push_back(mk(4'b0000, 1'b0, 3'd0, 4'b1000, 3'd3, 4'd4, 1'b0));
    ta.push_back(mk(4'b0000, 1'b0, 3'd0, 4'b0000, 3'd0, 4'd4, 1'b0));
    ta.push_back(mk(4'b0000, 1'b1, 3'd3, 4'b0000, 3'd0, 4'd5, 1'b0));
    ta.push_back(mk(4'b0000, 1'b1, 3'd2, 4'b0000, 3'd0, 4'd6, 1'b0));
    ta.push_back(mk(4'b0000, 1'b1, 3'd1, 4'b0000, 3'd0, 4'd7, 1'b0));
    ta.push_back(mk(4'b0000, 1'b1, 3'd0, 4'b0000, 3'd0, 4'd8, 1'b0));
    ta.push_back(mk(4'b0000, 1'b1, 3'd3, 4'b0000, 3'd0, 4'd8, 1'b1));
    ta.push_back(mk(4'b0000, 1'b0, 3'd0, 4'b0000, 3'd0, 4'd8, 1'b0));
    ta.push_back(mk(4'b0001, 1'b0, 3'd0, 4'b0000, 3'd0, 4'd8, 1'b0));
    ta.push_back(mk(4'b0000, 1'b1, 3'd3, 4'b0001, 3'd4, 4'd8, 1'b0));
    ta.push_back(mk(4'b0000, 1'b0, 3'd0, 4'b0000, 3'd0, 4'd8, 1'b0));
    ta.push_back(mk(4'b0101, 1'b0, 3'd0, 4'b0000, 3'd0, 4'd8, 1'b0));
    ta.push_back(mk(4'b0010, 1'b0, 3'd0, 4'b0100, 3'd5, 4'd7, 1'b0));
    ta.push_back(mk(4'b0000, 1'b0, 3'd0, 4'b0001, 3'd6, 4'd6, 1'b0));
    ta.push_back(mk(4'b0000, 1'b0, 3'd0, 4'b0010, 3'd7, 4'd5, 1'b0));
    ta.push_back(mk(4'b0000, 1'b0, 3'd0, 4'b0000, 3'd0, 4'd5, 1'b0));
    ta.push_back(mk(4'b1001, 1'b0, 3'd0, 4'b0000, 3'd0, 4'd5, 1'b0));
    ta.push_back(mk(4'b0000, 1'b0, 3'd0, 4'b1000, 3'd3, 4'd4, 1'b0));
    ta.push_back(mk(4'b0000, 1'b0, 3'd0, 4'b0001, 3'd2, 4'd3, 1'b0));
    ta.push_back(mk(4'b0000, 1'b0, 3'd0, 4'b0000, 3'd0, 4'd3, 1'b0));
    ta.push_back(mk(4'b0100, 1'b0, 3'd0, 4'b0000, 3'd0, 4'd3, 1'b0));
    ta.push_back(mk(4'b0100, 1'b0, 3'd0, 4'b0100, 3'd1, 4'd2, 1'b0));
    ta.push_back(mk(4'b0000, 1'b0, 3'd0, 4'b0000, 3'd0, 4'd2, 1'b0));
    ta.push_back(mk(4'b0010, 1'b0, 3'd0, 4'b0000, 3'd0, 4'd2, 1'b0));
    ta.push_back(mk(4'b0000, 1'b1, 3'd5, 4'b0010, 3'd0, 4'd2, 1'b0));
    ta.push_back(mk(4'b0000, 1'b0, 3'd0, 4'b0000, 3'd0, 4'd2, 1'b0));
    ta.push_back(mk(4'b1111, 1'b0, 3'd0, 4'b0000, 3'd0, 4'd2, 1'b0));
    ta.push_back(mk(4'b0000, 1'b0, 3'd0, 4'b0100, 3'd3, 4'd1, 1'b0));

    // Table B: serial channel-2 allocation until empty, then starvation and returns
    for (int k = 0; k < 8; k++) begin
      tb.push_back(mk(4'b0100, 1'b0, 3'd0, 4'b0000, 3'd0, 4'(8 - k), 1'b0));
      tb.push_back(mk(4'b0000, 1'b0, 3'd0, 4'b0100, 3'(k), 4'(7 - k), 1'b0));
    end
    tb.push_back(mk(4'b0100, 1'b0, 3'd0, 4'b0000, 3'd0, 4'd0, 1'b0));
    tb.push_back(mk(4'b0000, 1'b0, 3'd0, 4'b0000, 3'd0, 4'd0, 1'b0));
    tb.push_back(mk(4'b0000, 1'b1, 3'd5, 4'b0000, 3'd0, 4'd1, 1'b0));
    tb.push_back(mk(4'b0000, 1'b0, 3'd0, 4'b0100, 3'd5, 4'd0, 1'b0));
    tb.push_back(mk(4'b0001, 1'b1, 3'd7, 4'b0000, 3'd0, 4'd1, 1'b0));
    tb.push_back(mk(4'b0000, 1'b0, 3'd0, 4'b0001, 3'd7, 4'd0, 1'b0));
    tb.push_back(mk(4'b0010, 1'b0, 3'd0, 4'b0000, 3'd0, 4'd0, 1'b0));
    tb.push_back(mk(4'b0000, 1'b0, 3'd0, 4'b0000, 3'd0, 4'd0, 1'b0));
    tb.push_back(mk(4'b1000, 1'b1, 3'd6, 4'b0000, 3'd0, 4'd1, 1'b0));
    tb.push_back(mk(4'b0000, 1'b0, 3'd0, 4'b0010, 3'd6, 4'd0, 1'b0));
    tb.push_back(mk(4'b0000, 1'b0, 3'd0, 4'b0000, 3'd0, 4'd0, 1'b0));
    tb.push_back(mk(4'b0000, 1'b1, 3'd2, 4'b0000, 3'd0, 4'd1, 1'b0));
    tb.push_back(mk(4'b0000, 1'b0, 3'd0, 4'b1000, 3'd2, 4'd0, 1'b0));
    tb.push_back(mk(4'b0000, 1'b0, 3'd0, 4'b0000, 3'd0, 4'd0, 1'b0));

    do_reset(1'b0, "R1");
    for (int i = 0; i < ta.size(); i++) step(ta[i], $sformatf("A%0d", i));

    // Reset lands while channel 3 is still pending from the burst; its grant must vanish.
    sb_q.delete();
    do_reset(1'b1, "R2");
    for (int i = 0; i < tb.size(); i++) step(tb[i], $sformatf("B%0d", i));

    chk("sb_leftover", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/free_blk_alloc.md
FREE_BLK_ALLOC -- requirements
Module: free_blk_alloc

Interface
REQ-001 The block SHALL have parameter PORT_NUM, default 16, meaning the number of input channels served.
REQ-002 The block SHALL have parameter BLK_ADDR_WIDTH, default 11, meaning the block address width; block count BLK_NUM = 2**BLK_ADDR_WIDTH.
REQ-003 The block SHALL have port i_clk  input  1  single system clock; all logic on its rising edge.
REQ-004 The block SHALL have port i_rst_n  input  1  synchronous, active-low reset.
REQ-005 The block SHALL have port i_addr_req  input  PORT_NUM  per-channel one-cycle request pulse for one free block.
REQ-006 The block SHALL have port o_blk_addr_vld  output  PORT_NUM  one-hot grant pulse, one cycle, qualifying o_blk_addr.
REQ-007 The block SHALL have port o_blk_addr  output  BLK_ADDR_WIDTH  allocated block address, shared by all channels.
REQ-008 The block SHALL have port i_free_vld  input  1  return-a-block strobe from the read-out side.
REQ-009 The block SHALL have port i_free_addr  input  BLK_ADDR_WIDTH  block address being returned.
REQ-010 The block SHALL have port o_free_cnt  output  BLK_ADDR_WIDTH+1  number of blocks currently in the free list.
REQ-011 The block SHALL have port o_init_done  output  1  high once the free list is fully populated.
REQ-012 The block SHALL have port o_free_ovf  output  1  one-cycle pulse when a return is dropped because the list is full.

Function
REQ-013 The free list SHALL be a circular buffer of BLK_NUM entries with read pointer, write pointer and count; pointers wrap from BLK_NUM-1 to 0.
REQ-014 The FSM SHALL have two states: INIT (entered on reset) and RUN; INIT->RUN when the init counter has written entry BLK_NUM-1; no other transitions.
REQ-015 In INIT the block SHALL write address k into entry k on cycle k (k = 0..BLK_NUM-1), so o_free_cnt reaches BLK_NUM after BLK_NUM cycles and the list pops in ascending order.
REQ-016 o_init_done SHALL go high on the cycle the FSM is in RUN and stay high until reset.
REQ-017 A pending register (PORT_NUM bits) SHALL set bit p the cycle after i_addr_req[p] is high and SHALL clear bit p the cycle its grant issues; a request pulse arriving while bit p is already pending SHALL be merged (no second allocation).
REQ-018 Requests SHALL be latched in INIT as well; no grants issue in INIT.
REQ-019 In RUN, when any bit is pending and count > 0, the arbiter SHALL grant exactly one channel per cycle, round-robin: search starts at the channel after the last granted one, wrapping PORT_NUM-1 -> 0; after reset the last-granted pointer is PORT_NUM-1 (channel 0 has first priority).
REQ-020 Grant latency SHALL be one cycle: the pop occurs in the grant cycle; o_blk_addr_vld[p] and o_blk_addr are registered and valid on the following cycle.
REQ-021 When count = 0, no grant SHALL issue; pending bits SHALL be held until blocks are returned.
REQ-022 i_free_vld in RUN with count < BLK_NUM SHALL push i_free_addr; the address is poppable no earlier than the next cycle (no same-cycle bypass).
REQ-023 A simultaneous pop and push SHALL both occur with count unchanged, including at count = 0 (push accepted, no grant that cycle) and count = BLK_NUM (pop then push, both accepted).
REQ-024 i_free_vld with count = BLK_NUM and no pop in the same cycle SHALL be dropped and o_free_ovf pulsed the next cycle.
REQ-025 i_free_vld in INIT SHALL be ignored without an overflow pulse.
REQ-026 o_free_cnt SHALL be registered and reflect the count after the current cycle's push/pop.

Reset
REQ-027 With i_rst_n low at a clock edge, the block SHALL clear pointers, count, pending, init counter, all outputs (o_blk_addr_vld = 0, o_blk_addr = 0, o_free_cnt = 0, o_init_done = 0, o_free_ovf = 0), set the last-granted pointer to PORT_NUM-1, and enter INIT.
REQ-028 Reset asserted mid-operation SHALL discard all pending requests and list contents and restart INIT from entry 0.

Verification (PORT_NUM=4, BLK_ADDR_WIDTH=3)
REQ-029 Release reset, idle -> o_init_done rises 8 cycles later, o_free_cnt = 8.
REQ-030 After init, i_addr_req = 4'b1111 for one cycle -> grants on channels 0,1,2,3 on four consecutive cycles with addresses 0,1,2,3; o_free_cnt ends at 4.
REQ-031 Channel 2 requests 9 times serially without returns -> first 8 get addresses 0..7, ninth held pending; i_free_vld with address 5 -> channel 2 receives 5 two cycles after the strobe.
REQ-032 Count = 8, i_free_vld with address 3, no request -> o_free_ovf pulses once, o_free_cnt stays 8.
REQ-033 Count = 0, channel 1 pending, i_free_vld address 6 in same cycle as a new channel 3 request -> count 1, channel 1 granted address 6 next, channel 3 pending until another return.
REQ-034 Reset asserted during a grant burst -> all outputs 0 next cycle, pending cleared, INIT restarts, first post-init grant returns address 0.
